// File: rtl/space_wire_stat_reader.sv
// space_wire_stat_reader: snapshots all SpaceWire statistics counters atomically.
// It streams them out as a byte packet and issues the counter clear pulse.
// Packet: header (dump sequence number), then each counter MSB byte first.
// Optional build macro SPACE_WIRE_STAT_RD_CLEAR_ON_READ_EN: every completed
// dump is followed by a clear pulse (read-and-clear).
module space_wire_stat_reader #(
  parameter int NUM_CNT       = 8,
  parameter int CNT_W         = 32,
  parameter int CLR_PULSE_LEN = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [NUM_CNT*CNT_W-1:0] i_stat_bus,
  input  logic                     i_dump_start,
  input  logic                     i_clear_req,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic                     o_tx_last,
  output logic                     o_stat_clear,
  output logic                     o_busy,
  output logic [7:0]               o_dump_seq
);

  localparam int BPC   = CNT_W / 8;
  localparam int PKT   = 1 + NUM_CNT * BPC;
  localparam int PKT_W = 8 * PKT;
  localparam int IDX_W = $clog2(PKT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT - 1);
  localparam logic [7:0]       CLR_LAST = 8'(CLR_PULSE_LEN - 1);

`ifdef SPACE_WIRE_STAT_RD_CLEAR_ON_READ_EN
  localparam bit CLR_ON_READ = 1'b1;
`else
  localparam bit CLR_ON_READ = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SEND, CLEAR} state_t;

  state_t           state_reg, state_next;
  // Shadow of the whole packet in wire order; the top byte is always the one on o_tx_data.
  logic [PKT_W-1:0] shift_reg, shift_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [7:0]       seq_reg, seq_next;
  logic [7:0]       clr_cnt_reg, clr_cnt_next;
  logic             pend_reg, pend_next;
  logic [PKT_W-9:0] load_vec;

  // Reorder the live bus into wire order: counter 0 first, MSB byte first.
  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      for (gj = 0; gj < BPC; gj++) begin : g_byte
        assign load_vec[PKT_W-9-8*(gi*BPC+gj) -: 8] = i_stat_bus[gi*CNT_W+CNT_W-1-8*gj -: 8];
      end
    end
  endgenerate

  // State and datapath registers; reset aborts any dump or clear in progress.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      idx_reg     <= '0;
      seq_reg     <= '0;
      clr_cnt_reg <= '0;
      pend_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      idx_reg     <= idx_next;
      seq_reg     <= seq_next;
      clr_cnt_reg <= clr_cnt_next;
      pend_reg    <= pend_next;
    end
  end

  // Next-state logic: a pending clear beats a dump request in IDLE; dump requests elsewhere are dropped.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    idx_next     = idx_reg;
    seq_next     = seq_reg;
    clr_cnt_next = clr_cnt_reg;
    pend_next    = pend_reg;
    case (state_reg)
      IDLE: begin
        if (pend_reg) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
        end else if (i_dump_start) begin
          state_next = SEND;
          shift_next = {seq_reg, load_vec};
          idx_next   = '0;
        end
      end
      SEND: begin
        if (i_tx_ready) begin
          shift_next = shift_reg << 8;
          if (idx_reg == LAST_IDX) begin
            seq_next     = seq_reg + 8'd1;
            idx_next     = '0;
            clr_cnt_next = '0;
            state_next   = (pend_reg || CLR_ON_READ) ? CLEAR : IDLE;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      CLEAR: begin
        if (clr_cnt_reg == CLR_LAST) begin
          state_next = IDLE;
        end else begin
          clr_cnt_next = clr_cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Entering CLEAR consumes the request; a new request on the same edge re-arms it.
    if (state_next == CLEAR && state_reg != CLEAR) pend_next = 1'b0;
    if (i_clear_req) pend_next = 1'b1;
  end

  assign o_tx_valid   = (state_reg == SEND);
  assign o_tx_data    = shift_reg[PKT_W-1 -: 8];
  assign o_tx_last    = (state_reg == SEND) && (idx_reg == LAST_IDX);
  assign o_stat_clear = (state_reg == CLEAR);
  assign o_busy       = (state_reg != IDLE);
  assign o_dump_seq   = seq_reg;

endmodule

// File: tb/tb_space_wire_stat_reader.sv
// Directed testbench for space_wire_stat_reader (default parameters).
module tb_space_wire_stat_reader;

  localparam int NUM_CNT = 8;
  localparam int CNT_W   = 32;
  localparam int PKT     = 1 + NUM_CNT * CNT_W / 8;

`ifdef SPACE_WIRE_STAT_RD_CLEAR_ON_READ_EN
  localparam bit COR = 1'b1;
`else
  localparam bit COR = 1'b0;
`endif

  logic                     clk;
  logic                     rst_n;
  logic [NUM_CNT*CNT_W-1:0] stat_bus;
  logic                     dump_start;
  logic                     clear_req;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic                     tx_last;
  logic                     stat_clear;
  logic                     busy;
  logic [7:0]               dump_seq;

  int vectors     = 0;
  int miscompares = 0;

  logic [NUM_CNT*CNT_W-1:0] snap;

  space_wire_stat_reader #(
    .NUM_CNT(NUM_CNT),
    .CNT_W(CNT_W),
    .CLR_PULSE_LEN(4)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_stat_bus(stat_bus),
    .i_dump_start(dump_start),
    .i_clear_req(clear_req),
    .o_tx_data(tx_data),
    .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready),
    .o_tx_last(tx_last),
    .o_stat_clear(stat_clear),
    .o_busy(busy),
    .o_dump_seq(dump_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected packet byte p from a snapshot: header, then counters MSB first.
  function automatic logic [7:0] exp_byte(input logic [NUM_CNT*CNT_W-1:0] s,
                                          input logic [7:0] seq, input int p);
    logic [31:0] c;
    int k;
    int b;
    if (p == 0) return seq;
    k = (p - 1) / 4;
    b = (p - 1) % 4;
    c = s[k*32 +: 32];
    return c[31-8*b -: 8];
  endfunction

  task automatic set_bus(input logic [31:0] base);
    for (int k = 0; k < NUM_CNT; k++) stat_bus[k*32 +: 32] = base + 32'(k);
  endtask

  // Pulses i_dump_start for one clock; returns at the negedge where byte 0 should show.
  task automatic start_dump(input bit with_clr);
    @(negedge clk);
    dump_start = 1'b1;
    clear_req  = with_clr;
    @(negedge clk);
    dump_start = 1'b0;
    clear_req  = 1'b0;
  endtask

  // Receives a whole packet; returns at the negedge after the final acceptance.
  task automatic recv_dump(input logic [7:0] seq, input logic [NUM_CNT*CNT_W-1:0] s,
                           input bit throttle, input int mut_at, input int clr_at);
    int  p;
    int  cyc;
    bit  rdy;
    bit  pulsed;
    p = 0; cyc = 0; pulsed = 1'b0;
    while (p < PKT && cyc < 1000) begin
      cyc++;
      clear_req = 1'b0;
      chk("tx_valid", 32'(tx_valid), 32'd1);
      chk("tx_data", 32'(tx_data), 32'(exp_byte(s, seq, p)));
      chk("tx_last", 32'(tx_last), 32'(p == PKT - 1));
      if (p == mut_at) stat_bus = ~stat_bus;
      if (p == clr_at && !pulsed) begin
        clear_req = 1'b1;
        pulsed    = 1'b1;
      end
      rdy = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_ready = rdy;
      @(negedge clk);
      if (rdy) p++;
    end
    clear_req = 1'b0;
    tx_ready  = 1'b1;
    if (p < PKT) chk("dump_timeout", 32'(p), 32'(PKT));
  endtask

  // Checks the cycles after the final acceptance: valid drop, sequence, clear pulse, busy.
  task automatic post_dump(input logic [7:0] seq_exp, input bit clr_exp);
    int n;
    chk("valid_after", 32'(tx_valid), 32'd0);
    chk("dump_seq", 32'(dump_seq), 32'(seq_exp));
    chk("clear_first", 32'(stat_clear), 32'(clr_exp));
    n = int'(stat_clear);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n += int'(stat_clear);
    end
    chk("clear_len", 32'(n), clr_exp ? 32'd4 : 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic do_dump(input string name, input logic [7:0] seq, input bit throttle,
                         input int mut_at, input int clr_at, input bit clr_exp);
    snap = stat_bus;
    start_dump(1'b0);
    recv_dump(seq, snap, throttle, mut_at, clr_at);
    post_dump(seq + 8'd1, clr_exp);
    $display("%s: dump seq=%02h done, dump_seq=%02h, miscompares so far %0d",
             name, seq, dump_seq, miscompares);
  endtask

  initial begin
    int n;
    int v;
    rst_n = 1'b0; dump_start = 1'b0; clear_req = 1'b0; tx_ready = 1'b1; stat_bus = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_last", 32'(tx_last), 32'd0);
    chk("rst_clear", 32'(stat_clear), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_seq", 32'(dump_seq), 32'd0);
    $display("reset: outputs checked");

    // Basic dump at full rate: 00,10,00,00,00,10,00,00,01,...
    set_bus(32'h1000_0000);
    do_dump("basic", 8'h00, 1'b0, -1, -1, COR);

    // Throttled ready, live bus inverted mid-dump.
    for (int k = 0; k < NUM_CNT; k++) stat_bus[k*32 +: 32] = $urandom;
    do_dump("throttle", 8'h01, 1'b1, 12, -1, COR);

    // Clear request during byte 5: dump intact, then one 4-clock clear.
    set_bus(32'hA5A5_0000);
    do_dump("clear_mid", 8'h02, 1'b0, -1, 5, 1'b1);

    // Dump and clear together in IDLE; a dump request during CLEAR is ignored.
    set_bus(32'h0BAD_0000);
    snap = stat_bus;
    start_dump(1'b1);
    recv_dump(8'h03, snap, 1'b0, -1, -1);
    chk("t4_seq", 32'(dump_seq), 32'h04);
    chk("t4_clear_first", 32'(stat_clear), 32'd1);
    n = int'(stat_clear);
    v = 0;
    @(negedge clk);
    n += int'(stat_clear);
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    n += int'(stat_clear);
    v += int'(tx_valid);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n += int'(stat_clear);
      v += int'(tx_valid);
    end
    chk("t4_clear_len", 32'(n), 32'd4);
    chk("t4_no_valid", 32'(v), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    $display("dump_and_clear: clear pulses=%0d, valid cycles=%0d", n, v);

    // 256 dumps from reset: header runs 00..FF and the sequence wraps.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      set_bus(32'(i) << 16);
      do_dump("seq_run", 8'(i), 1'b0, -1, -1, COR);
    end
    chk("seq_wrap", 32'(dump_seq), 32'h00);
    set_bus(32'h7777_0000);
    do_dump("after_wrap", 8'h00, 1'b0, -1, -1, COR);

    // Reset asserted while byte 10 is on the bus: valid falls without a clock edge.
    set_bus(32'h5555_0000);
    snap = stat_bus;
    start_dump(1'b0);
    for (int p = 0; p < 10; p++) @(negedge clk);
    chk("rst_mid_b10", 32'(tx_data), 32'(exp_byte(snap, 8'h01, 10)));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(tx_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_seq", 32'(dump_seq), 32'd0);
    chk("rst_mid_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset_mid_dump: dump_seq=%02h valid=%0d", dump_seq, tx_valid);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
